// File: rtl/vacc_sched.sv
// Run-control sequencer for a vacc vector accumulator: arm/clear/align/run FSM,
// dump counting, timestamping and buffer ping-pong. Optional watchdog: VACC_SCHED_WATCHDOG_EN.
module vacc_sched #(
  parameter int unsigned VECTOR_WIDTH = 11,
  parameter int unsigned TS_WIDTH     = 48,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned SYNC_TIMEOUT = 2**20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    sync_in,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [1:0]              mode,
  input  logic [CNT_WIDTH-1:0]    n_dumps,
  input  logic                    ack,
  input  logic                    dump_we,
  input  logic [VECTOR_WIDTH-1:0] dump_addr,
  output logic                    vacc_rst,
  output logic                    vacc_sync,
  output logic                    vacc_trig,
  output logic                    busy,
  output logic                    buf_sel,
  output logic                    dump_done,
  output logic [CNT_WIDTH-1:0]    dump_count,
  output logic [TS_WIDTH-1:0]     timestamp,
  output logic                    overrun,
  output logic                    sync_lost
);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_SYNC, ALIGN, RUN} state_t;

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [VECTOR_WIDTH-1:0] LAST_ADDR = {{(VECTOR_WIDTH-1){1'b1}}, 1'b0};

  state_t                  state, state_nx;
  logic [RC_W-1:0]         rcnt, rcnt_nx;
  logic [1:0]              mode_q, mode_nx;
  logic [CNT_WIDTH-1:0]    nd_q, nd_nx;
  logic [TS_WIDTH-1:0]     sample_cnt;
  logic                    dump_we_q;
  logic [VECTOR_WIDTH-1:0] dump_addr_q;
  logic                    pending, pend_nx;
  logic                    vacc_rst_nx, vacc_sync_nx, vacc_trig_nx, dump_done_nx;
  logic                    buf_nx, ovr_nx;
  logic [CNT_WIDTH-1:0]    cnt_nx, cnt_inc;
  logic [TS_WIDTH-1:0]     ts_nx;
  logic                    dump_end, run_finished;

`ifdef VACC_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
  logic [WD_W-1:0] wd, wd_nx;
  logic            lost_nx;
`endif

  // A dump is only counted if the readout actually reached the final address.
  assign dump_end = (state == RUN) && dump_we_q && !dump_we && (dump_addr_q == LAST_ADDR);
  assign cnt_inc  = (dump_count == '1) ? dump_count : dump_count + CNT_WIDTH'(1);
  assign run_finished = (mode_q == 2'd2) ? 1'b0 :
                        (mode_q == 2'd1) ? (cnt_inc >= nd_q) : 1'b1;
  assign busy = (state != IDLE);

  always_comb begin
    state_nx     = state;
    rcnt_nx      = rcnt;
    mode_nx      = mode_q;
    nd_nx        = nd_q;
    pend_nx      = pending;
    vacc_rst_nx  = 1'b0;
    vacc_sync_nx = 1'b0;
    vacc_trig_nx = 1'b0;
    dump_done_nx = 1'b0;
    buf_nx       = buf_sel;
    ovr_nx       = overrun;
    cnt_nx       = dump_count;
    ts_nx        = timestamp;
`ifdef VACC_SCHED_WATCHDOG_EN
    lost_nx      = sync_lost;
    wd_nx        = '0;
`endif
    if (ack) pend_nx = 1'b0;
    if (abort) begin
      state_nx    = IDLE;
      vacc_rst_nx = 1'b1;
    end else begin
      unique case (state)
        IDLE: if (arm) begin
          state_nx    = CLEAR;
          vacc_rst_nx = 1'b1;
          rcnt_nx     = '0;
          cnt_nx      = '0;
          ovr_nx      = 1'b0;
          pend_nx     = 1'b0;
          buf_nx      = 1'b0;
          mode_nx     = mode;
          nd_nx       = (n_dumps == '0) ? CNT_WIDTH'(1) : n_dumps;
`ifdef VACC_SCHED_WATCHDOG_EN
          lost_nx     = 1'b0;
`endif
        end
        CLEAR: begin
          if (rcnt == RC_W'(RST_CYCLES - 1)) begin
            state_nx = WAIT_SYNC;
          end else begin
            vacc_rst_nx = 1'b1;
            rcnt_nx     = rcnt + RC_W'(1);
          end
        end
        WAIT_SYNC: if (sync_in) begin
          vacc_sync_nx = 1'b1;
          state_nx     = ALIGN;
        end
        ALIGN: if (sync_in) begin
          vacc_trig_nx = 1'b1;
          ts_nx        = sample_cnt;
          state_nx     = RUN;
        end
        RUN: if (dump_end) begin
          dump_done_nx = 1'b1;
          cnt_nx       = cnt_inc;
          buf_nx       = !buf_sel;
          // Same-cycle ack retires the older buffer, so only an un-acked one overruns.
          if (pending && !ack) ovr_nx = 1'b1;
          pend_nx      = 1'b1;
          state_nx     = run_finished ? IDLE : ALIGN;
        end
        default: state_nx = IDLE;
      endcase
    end
`ifdef VACC_SCHED_WATCHDOG_EN
    if (!abort && (state == WAIT_SYNC || state == ALIGN) && !sync_in) begin
      if (wd == WD_W'(SYNC_TIMEOUT - 1)) begin
        lost_nx     = 1'b1;
        state_nx    = IDLE;
        vacc_rst_nx = 1'b1;
      end else begin
        wd_nx = wd + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rcnt        <= '0;
      mode_q      <= '0;
      nd_q        <= '0;
      pending     <= 1'b0;
      vacc_rst    <= 1'b0;
      vacc_sync   <= 1'b0;
      vacc_trig   <= 1'b0;
      dump_done   <= 1'b0;
      buf_sel     <= 1'b0;
      overrun     <= 1'b0;
      dump_count  <= '0;
      timestamp   <= '0;
      sample_cnt  <= '0;
      dump_we_q   <= 1'b0;
      dump_addr_q <= '0;
    end else if (ce) begin
      state       <= state_nx;
      rcnt        <= rcnt_nx;
      mode_q      <= mode_nx;
      nd_q        <= nd_nx;
      pending     <= pend_nx;
      vacc_rst    <= vacc_rst_nx;
      vacc_sync   <= vacc_sync_nx;
      vacc_trig   <= vacc_trig_nx;
      dump_done   <= dump_done_nx;
      buf_sel     <= buf_nx;
      overrun     <= ovr_nx;
      dump_count  <= cnt_nx;
      timestamp   <= ts_nx;
      sample_cnt  <= sample_cnt + TS_WIDTH'(1);
      dump_we_q   <= dump_we;
      dump_addr_q <= dump_addr;
    end
  end

`ifdef VACC_SCHED_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd        <= '0;
      sync_lost <= 1'b0;
    end else if (ce) begin
      wd        <= wd_nx;
      sync_lost <= lost_nx;
    end
  end
`else
  assign sync_lost = 1'b0;
`endif

endmodule

// File: tb/tb_vacc_sched.sv
// Self-checking bench for vacc_sched: control-sequence vector table, spectrum-level
// stimulus with a dump-result scoreboard, abort/freeze/reset corner sequences.
module tb_vacc_sched;
  localparam int unsigned VW = 11;
  localparam int unsigned NS = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b1, sync_in = 1'b0, arm = 1'b0, abort = 1'b0, ack = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [15:0]   n_dumps = 16'd0;
  logic          dump_we = 1'b0;
  logic [VW-1:0] dump_addr = '0;
  logic          vacc_rst, vacc_sync, vacc_trig, busy, buf_sel, dump_done, overrun, sync_lost;
  logic [15:0]   dump_count;
  logic [47:0]   timestamp;

  vacc_sched #(.VECTOR_WIDTH(VW), .TS_WIDTH(48), .CNT_WIDTH(16), .RST_CYCLES(4),
               .SYNC_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .ce(ce), .sync_in(sync_in), .arm(arm), .abort(abort),
    .mode(mode), .n_dumps(n_dumps), .ack(ack), .dump_we(dump_we), .dump_addr(dump_addr),
    .vacc_rst(vacc_rst), .vacc_sync(vacc_sync), .vacc_trig(vacc_trig), .busy(busy),
    .buf_sel(buf_sel), .dump_done(dump_done), .dump_count(dump_count),
    .timestamp(timestamp), .overrun(overrun), .sync_lost(sync_lost));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample-counter reference: one count per ce edge out of reset.
  logic [47:0] smp = '0;
  always @(posedge clk) begin
    if (rst) smp <= '0;
    else if (ce) smp <= smp + 48'd1;
  end

  // Scoreboard of expected dump completions.
  typedef struct {
    logic [15:0] cnt;
    logic        bsel;
    logic        ovr;
    logic        busy;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_cnt, m_target;
  logic        m_buf, m_ovr, m_pend;

  task automatic push_end(input logic ack_now);
    exp_t e;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_buf = ~m_buf;
    if (m_pend && !ack_now) m_ovr = 1'b1;
    m_pend = 1'b1;
    e.cnt  = m_cnt;
    e.bsel = m_buf;
    e.ovr  = m_ovr;
    e.busy = !(m_target != 16'd0 && m_cnt >= m_target);
    sb.push_back(e);
  endtask

  initial begin : monitor
    logic cep;
    exp_t e;
    forever begin
      @(negedge clk);
      cep = ce;
      @(posedge clk);
      #2;
      if (!rst && cep && dump_done) begin
        if (sb.size() == 0) begin
          chk("dump_done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_dump_count", dump_count, e.cnt);
          chk("sb_buf_sel", buf_sel, e.bsel);
          chk("sb_overrun", overrun, e.ovr);
          chk("sb_busy", busy, e.busy);
        end
      end
    end
  end

  task automatic start_run(input logic [1:0] md, input logic [15:0] nd);
    mode = md; n_dumps = nd; arm = 1'b1;
    tick();
    arm = 1'b0; mode = 2'd0; n_dumps = 16'd7;
    m_cnt = '0; m_buf = 1'b0; m_ovr = 1'b0; m_pend = 1'b0;
    m_target = (md == 2'd2) ? 16'd0 : (md == 2'd1) ? ((nd == 16'd0) ? 16'd1 : nd) : 16'd1;
    chk("arm_busy", busy, 1);
    chk("arm_vacc_rst", vacc_rst, 1);
    chk("arm_dump_count", dump_count, 0);
    chk("arm_sync_lost", sync_lost, 0);
    repeat (4) tick();
    chk("clear_end_vacc_rst", vacc_rst, 0);
  endtask

  // One spectrum period: sync on its first cycle, optional dump readout across it.
  task automatic spectrum(input logic dump, input logic good, input logic end_exp,
                          input logic ack0, input logic ack1, input logic exp_sync,
                          input logic exp_trig, input logic freeze);
    logic [47:0] ts_exp;
    for (int k = 0; k < NS; k++) begin
      sync_in   = (k == 0);
      ack       = (ack0 && k == 0) || (ack1 && k == 1);
      dump_we   = dump;
      dump_addr = good ? VW'(k - 1) : VW'(k - 2);
      if (k == 0 && end_exp) push_end(ack0);
      if (k == 1 && ack1) m_pend = 1'b0;
      ts_exp = smp;
      tick();
      if (k == 0) begin
        chk("vacc_sync", vacc_sync, exp_sync);
        chk("vacc_trig", vacc_trig, exp_trig);
        if (exp_trig) chk("timestamp", timestamp, ts_exp);
        if (freeze) begin
          ce = 1'b0; sync_in = 1'b0;
          for (int f = 0; f < 10; f++) begin
            tick();
            chk("freeze_trig", vacc_trig, 1);
            chk("freeze_ts", timestamp, ts_exp);
            chk("freeze_busy", busy, 1);
            chk("freeze_count", dump_count, 0);
          end
          ce = 1'b1;
        end
      end
    end
    sync_in = 1'b0; ack = 1'b0; dump_we = 1'b0;
  endtask

  typedef struct {
    logic a, b, s;
    logic e_rst, e_busy, e_sync;
  } vec_t;
  vec_t tbl[13];

  initial begin : main
    int n;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_vacc_rst", vacc_rst, 0);
    chk("rst_trig", vacc_trig, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_count", dump_count, 0);
    chk("rst_ts", timestamp, 0);
    chk("rst_buf", buf_sel, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_lost", sync_lost, 0);

    for (int i = 0; i < 13; i++) begin
      arm = tbl[i].a; abort = tbl[i].b; sync_in = tbl[i].s;
      tick();
      chk($sformatf("vec%0d_vacc_rst", i), vacc_rst, tbl[i].e_rst);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_vacc_sync", i), vacc_sync, tbl[i].e_sync);
    end
    arm = 1'b0; abort = 1'b0; sync_in = 1'b0;

`ifndef VACC_SCHED_WATCHDOG_EN
    // Single dump, arm at sample 100, syncs at 1000/3048, ce freeze after trig.
    n = 0;
    while (smp != 48'd100 && n < 200) begin tick(); n++; end
    start_run(2'd0, 16'd0);
    n = 0;
    while (smp < 48'd1000 && n < 2000) begin tick(); n++; end
    chk("smp_at_sync1", smp, 1000);
    spectrum(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    spectrum(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    spectrum(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_timestamp", timestamp, 3048);

    // n_dumps=3 with ack after each dump.
    start_run(2'd1, 16'd3);
    spectrum(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int d = 0; d < 3; d++) begin
      spectrum(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      spectrum(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("t2_count", dump_count, 3);
    chk("t2_ovr", overrun, 0);
    chk("t2_busy", busy, 0);

    // Continuous, no ack; a short readout in between must not count.
    start_run(2'd2, 16'd0);
    spectrum(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    spectrum(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    spectrum(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    spectrum(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    spectrum(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_bad_dump_count", dump_count, 1);
    spectrum(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    spectrum(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    spectrum(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    spectrum(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_count", dump_count, 3);
    chk("t3_ovr", overrun, 1);
    chk("t3_busy", busy, 1);

    // Abort mid-readout.
    sync_in = 1'b1; dump_we = 1'b1; dump_addr = '1;
    tick();
    chk("t4_trig", vacc_trig, 1);
    sync_in = 1'b0;
    for (int k = 1; k < 500; k++) begin dump_addr = VW'(k - 1); tick(); end
    abort = 1'b1;
    tick();
    abort = 1'b0; dump_we = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_vacc_rst", vacc_rst, 1);
    chk("abort_count_hold", dump_count, 3);
    tick();
    chk("abort_vacc_rst_end", vacc_rst, 0);
    chk("abort_idle", busy, 0);
`endif

`ifdef VACC_SCHED_WATCHDOG_EN
    start_run(2'd0, 16'd0);
    n = 0;
    while (!sync_lost && n < 200) begin tick(); n++; end
    chk("wd_cycles", n, 64);
    chk("wd_lost", sync_lost, 1);
    chk("wd_idle", busy, 0);
    chk("wd_vacc_rst", vacc_rst, 1);
    tick();
    chk("wd_vacc_rst_end", vacc_rst, 0);
`else
    start_run(2'd0, 16'd0);
    repeat (200) tick();
    chk("nowd_lost", sync_lost, 0);
    chk("nowd_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif

    // Asynchronous reset in the middle of CLEAR.
    mode = 2'd0; arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("pre_rst_vacc_rst", vacc_rst, 1);
    chk("arm_clears_lost", sync_lost, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vacc_rst", vacc_rst, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ts", timestamp, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
